// File: rtl/mem_access_if.sv
// Request/response handshake plus data-memory bus seen by mem_access_master.
// The master modport is the block itself; slave is the CPU/memory side.
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_dir;
  logic [31:0] mem_data_input;
  logic        mem_rd;
  logic        mem_wd;
  logic [31:0] mem_data_output;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_data_output,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_dir, mem_data_input, mem_rd, mem_wd
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_data_output,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_dir, mem_data_input, mem_rd, mem_wd
  );
endinterface

// File: rtl/mem_access_master.sv
// Multicycle load/store initiator for the data memory: sub-word access with
// extension, read-modify-write for byte/half stores, alignment and window checks.
module mem_access_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input logic          clk,
  input logic          rst_n,
  mem_access_if.master bus
);

  // Window end is computed one bit wider so a window touching 2^32 cannot wrap.
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [31:0] addr, addr_nx;
  logic [1:0]  size, size_nx;
  logic        sgn, sgn_nx;
  logic [31:0] wdata, wdata_nx;

  logic        ready_nx, resp_valid_nx, resp_err_nx, mem_rd_nx, mem_wd_nx;
  logic [31:0] resp_rdata_nx, mem_dir_nx, mem_wdata_nx;
  logic        req_err;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sg, input logic [1:0] k);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{k, 3'b000} +: 8];
    h = w[{k[1], 4'b0000} +: 16];
    case (sz)
      2'd0:    load_extract = sg ? {{24{b[7]}}, b} : {24'd0, b};
      2'd1:    load_extract = sg ? {{16{h[15]}}, h} : {16'd0, h};
      default: load_extract = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] k);
    logic [31:0] r;
    r = old;
    case (sz)
      2'd0:    r[{k, 3'b000} +: 8] = wd[7:0];
      2'd1:    r[{k[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Request screening: illegal size, misalignment, or outside the memory window.
  always_comb begin
    req_err = 1'b0;
    if (bus.req_size == 2'd3) begin
      req_err = 1'b1;
    end else if (bus.req_size == 2'd1 && bus.req_addr[0] != 1'b0) begin
      req_err = 1'b1;
    end else if (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00) begin
      req_err = 1'b1;
    end else if (bus.req_addr < BASE_ADDR || {1'b0, bus.req_addr} >= WIN_END) begin
      req_err = 1'b1;
    end else begin
      req_err = 1'b0;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_nx      = state;
    addr_nx       = addr;
    size_nx       = size;
    sgn_nx        = sgn;
    wdata_nx      = wdata;
    ready_nx      = 1'b0;
    resp_valid_nx = 1'b0;
    resp_err_nx   = 1'b0;
    resp_rdata_nx = 32'd0;
    mem_rd_nx     = 1'b0;
    mem_wd_nx     = 1'b0;
    mem_dir_nx    = 32'd0;
    mem_wdata_nx  = 32'd0;
    case (state)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          addr_nx  = bus.req_addr;
          size_nx  = bus.req_size;
          sgn_nx   = bus.req_signed;
          wdata_nx = bus.req_wdata;
          if (req_err) begin
            state_nx      = RESP;
            resp_valid_nx = 1'b1;
            resp_err_nx   = 1'b1;
          end else if (!bus.req_we) begin
            state_nx   = RD;
            mem_rd_nx  = 1'b1;
            mem_dir_nx = {bus.req_addr[31:2], 2'b00};
          end else if (bus.req_size == 2'd2) begin
            state_nx     = WR;
            mem_wd_nx    = 1'b1;
            mem_dir_nx   = {bus.req_addr[31:2], 2'b00};
            mem_wdata_nx = bus.req_wdata;
          end else begin
            state_nx   = RMW_RD;
            mem_rd_nx  = 1'b1;
            mem_dir_nx = {bus.req_addr[31:2], 2'b00};
          end
        end else begin
          ready_nx = 1'b1;
        end
      end
      RD: begin
        state_nx      = RESP;
        resp_valid_nx = 1'b1;
        resp_rdata_nx = load_extract(bus.mem_data_output, size, sgn, addr[1:0]);
      end
      RMW_RD: begin
        // Old word is only valid this cycle, so the merge lands directly in the write-data flop.
        state_nx     = WR;
        mem_wd_nx    = 1'b1;
        mem_dir_nx   = {addr[31:2], 2'b00};
        mem_wdata_nx = store_merge(bus.mem_data_output, wdata, size, addr[1:0]);
      end
      WR: begin
        state_nx      = RESP;
        resp_valid_nx = 1'b1;
      end
      RESP: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
      end
      default: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
      end
    endcase
  end

  // State, latched request fields and all outputs are flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      addr               <= 32'd0;
      size               <= 2'd0;
      sgn                <= 1'b0;
      wdata              <= 32'd0;
      bus.req_ready      <= 1'b1;
      bus.resp_valid     <= 1'b0;
      bus.resp_err       <= 1'b0;
      bus.resp_rdata     <= 32'd0;
      bus.mem_rd         <= 1'b0;
      bus.mem_wd         <= 1'b0;
      bus.mem_dir        <= 32'd0;
      bus.mem_data_input <= 32'd0;
    end else begin
      state              <= state_nx;
      addr               <= addr_nx;
      size               <= size_nx;
      sgn                <= sgn_nx;
      wdata              <= wdata_nx;
      bus.req_ready      <= ready_nx;
      bus.resp_valid     <= resp_valid_nx;
      bus.resp_err       <= resp_err_nx;
      bus.resp_rdata     <= resp_rdata_nx;
      bus.mem_rd         <= mem_rd_nx;
      bus.mem_wd         <= mem_wd_nx;
      bus.mem_dir        <= mem_dir_nx;
      bus.mem_data_input <= mem_wdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// Self-checking bench for mem_access_master: table of load/store vectors through a
// response scoreboard, plus back-to-back and reset-during-write sequences.
module tb_mem_access_master;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwd;
    logic        chk;
    int          idx;
    logic [31:0] mval;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   nrd = 0;
  int   nwd = 0;
  int   last_resp = 0;
  logic [31:0] mem [64];
  sb_t  sb [$];
  vec_t tbl [22];

  mem_access_if bif ();

  mem_access_master #(.BASE_ADDR(32'h0040_0000), .DEPTH_WORDS(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational read, write on the edge ending a mem_wd cycle.
  assign bif.mem_data_output = mem[bif.mem_dir[7:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[1]  <= 32'h8FF3_AAAA;
      mem[2]  <= 32'h1122_3344;
      mem[63] <= 32'hCAFE_F00D;
    end else if (bif.mem_wd) begin
      mem[bif.mem_dir[7:2]] <= bif.mem_data_input;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t ld(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                              input logic [31:0] rd);
    vec_t v;
    v = '{1'b0, sz, sg, a, 32'h0, 1'b0, rd, 2, 1, 0, 1'b0, 0, 32'h0};
    return v;
  endfunction

  function automatic vec_t st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                              input int ix, input logic [31:0] mv);
    vec_t v;
    v = '{1'b1, sz, 1'b0, a, wd, 1'b0, 32'h0, (sz == 2'd2) ? 2 : 3,
          (sz == 2'd2) ? 0 : 1, 1, 1'b1, ix, mv};
    return v;
  endfunction

  function automatic vec_t er(input logic w, input logic [1:0] sz, input logic [31:0] a);
    vec_t v;
    v = '{w, sz, 1'b1, a, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, 0, 0, 1'b1, 0, 32'h0};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bif.req_we     = v.we;
    bif.req_size   = v.size;
    bif.req_signed = v.sgn;
    bif.req_addr   = v.addr;
    bif.req_wdata  = v.wdata;
    bif.req_valid  = 1'b1;
  endtask

  task automatic issue(input vec_t v, input bit keep, output int acc);
    int n;
    sb_t e;
    @(negedge clk);
    drive(v);
    n = 0;
    while (!bif.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (n >= 20) begin
      check("accept_timeout", 32'(n), 32'd0);
    end else begin
      e.v = v;
      e.acc = cyc;
      sb.push_back(e);
    end
    if (!keep) begin
      @(negedge clk);
      bif.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int acc1, acc2;
    bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_size = 2'd0;
    bif.req_signed = 1'b0; bif.req_addr = 32'h0; bif.req_wdata = 32'h0;

    tbl[0]  = ld(2'd2, 1'b0, 32'h0040_0004, 32'h8FF3_AAAA);
    tbl[1]  = ld(2'd0, 1'b1, 32'h0040_0005, 32'hFFFF_FFAA);
    tbl[2]  = ld(2'd0, 1'b0, 32'h0040_0005, 32'h0000_00AA);
    tbl[3]  = ld(2'd1, 1'b1, 32'h0040_0006, 32'hFFFF_8FF3);
    tbl[4]  = ld(2'd1, 1'b0, 32'h0040_0006, 32'h0000_8FF3);
    tbl[5]  = ld(2'd0, 1'b1, 32'h0040_0008, 32'h0000_0044);
    tbl[6]  = ld(2'd1, 1'b1, 32'h0040_0008, 32'h0000_3344);
    tbl[7]  = ld(2'd0, 1'b0, 32'h0040_000B, 32'h0000_0011);
    tbl[8]  = ld(2'd2, 1'b1, 32'h0040_00FC, 32'hCAFE_F00D);
    tbl[9]  = st(2'd0, 32'h0040_0006, 32'h0000_0055, 1, 32'h8F55_AAAA);
    tbl[10] = st(2'd1, 32'h0040_0008, 32'hFFFF_BEEF, 2, 32'h1122_BEEF);
    tbl[11] = st(2'd2, 32'h0040_000C, 32'hA5A5_5A5A, 3, 32'hA5A5_5A5A);
    tbl[12] = st(2'd0, 32'h0040_000F, 32'h1234_5677, 3, 32'h77A5_5A5A);
    tbl[13] = er(1'b0, 2'd1, 32'h0040_0001);
    tbl[14] = er(1'b0, 2'd2, 32'h003F_FFFC);
    tbl[15] = er(1'b0, 2'd2, 32'h0040_0100);
    tbl[16] = er(1'b0, 2'd3, 32'h0040_0004);
    tbl[17] = er(1'b1, 2'd2, 32'h0040_0002);
    tbl[18] = ld(2'd2, 1'b0, 32'h0040_0000, 32'h0000_0000);
    tbl[19] = ld(2'd1, 1'b1, 32'h0040_00FE, 32'hFFFF_CAFE);
    tbl[20] = er(1'b1, 2'd0, 32'hFFFF_FFFF);
    tbl[21] = ld(2'd0, 1'b0, 32'h0040_0006, 32'h0000_0055);

    // Response monitor and bus-protocol watch.
    fork
      forever begin
        sb_t e;
        @(negedge clk);
        if (rst_n) begin
          if (bif.mem_rd || bif.mem_wd) begin
            check("rd_wd_exclusive", {31'd0, bif.mem_rd & bif.mem_wd}, 32'd0);
          end else begin
            check("bus_idle_zero", bif.mem_dir | bif.mem_data_input, 32'd0);
          end
          if (bif.mem_rd) nrd++;
          if (bif.mem_wd) nwd++;
          if (bif.resp_valid) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
              e = sb.pop_front();
              check("resp_err", {31'd0, bif.resp_err}, {31'd0, e.v.err});
              check("resp_rdata", bif.resp_rdata, e.v.rdata);
              check("latency", 32'(cyc - e.acc), 32'(e.v.lat));
              check("mem_rd_cycles", 32'(nrd), 32'(e.v.nrd));
              check("mem_wd_cycles", 32'(nwd), 32'(e.v.nwd));
              check("ready_low_in_resp", {31'd0, bif.req_ready}, 32'd0);
              if (e.v.chk) check("mem_word", mem[e.v.idx], e.v.mval);
            end
            last_resp = cyc;
            nrd = 0;
            nwd = 0;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bif.req_ready}, 32'd1);
    check("rst_resp", {30'd0, bif.resp_valid, bif.resp_err}, 32'd0);
    check("rst_mem_ctl", {30'd0, bif.mem_rd, bif.mem_wd}, 32'd0);
    preload = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      issue(tbl[i], 1'b0, acc1);
    end
    drain();

    // Back-to-back: valid held high across both requests.
    issue(ld(2'd2, 1'b0, 32'h0040_0004, 32'h8F55_AAAA), 1'b1, acc1);
    issue(st(2'd2, 32'h0040_0014, 32'h0BAD_F00D, 5, 32'h0BAD_F00D), 1'b0, acc2);
    check("b2b_spacing", 32'(acc2 - last_resp), 32'd1);
    check("b2b_gap", 32'(acc2 - acc1), 32'd3);
    drain();

    // Reset asserted during WR must kill the write at once.
    @(negedge clk);
    drive(st(2'd2, 32'h0040_0010, 32'h1234_5678, 4, 32'h0));
    check("t1_ready", {31'd0, bif.req_ready}, 32'd1);
    @(negedge clk);
    bif.req_valid = 1'b0;
    check("t1_wd_high", {31'd0, bif.mem_wd}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("t1_wd_async_drop", {31'd0, bif.mem_wd}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nrd = 0;
    nwd = 0;
    @(negedge clk);
    check("t1_no_write", mem[4], 32'h0);
    check("t1_ready", {31'd0, bif.req_ready}, 32'd1);
    check("t1_outs", {28'd0, bif.resp_valid, bif.resp_err, bif.mem_rd, bif.mem_wd}, 32'd0);
    check("t1_rdata", bif.resp_rdata, 32'd0);
    check("t1_bus", bif.mem_dir | bif.mem_data_input, 32'd0);

    // Block still usable after the aborted store.
    issue(ld(2'd0, 1'b1, 32'h0040_0007, 32'hFFFF_FF8F), 1'b0, acc1);
    drain();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
